corespi_txn_sequencer: RTL and testbench



---
 rtl/corespi_txn_sequencer_if.sv | 22 ++
 rtl/corespi_txn_sequencer.sv | 178 +++++++++++++++++
 tb/tb_corespi_txn_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/corespi_txn_sequencer_if.sv
// APB3 link between the SPI transaction sequencer (master) and CoreSPI (slave).
// Signals: m_paddr[6:0], m_psel, m_penable, m_pwrite, m_pwdata[7:0] / m_prdata[7:0], m_pready, m_pslverr.
interface corespi_txn_sequencer_if;
    logic [6:0] m_paddr;
    logic       m_psel;
    logic       m_penable;
    logic       m_pwrite;
    logic [7:0] m_pwdata;
    logic [7:0] m_prdata;
    logic       m_pready;
    logic       m_pslverr;

    modport master (
        output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        input  m_prdata, m_pready, m_pslverr
    );

    modport slave (
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        output m_prdata, m_pready, m_pslverr
    );
endinterface

// File: rtl/corespi_txn_sequencer.sv
// APB3 master sharing one CoreSPI between two byte requesters, round-robin per burst.
// Ports: PCLK, PRESETN; bus (APB master); req_valid/data/last/ready; rsp_valid/data/err; busy.
module corespi_txn_sequencer (
    input  logic        PCLK,
    input  logic        PRESETN,
    corespi_txn_sequencer_if.master bus,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        busy
);
    localparam logic [6:0] ADDR_CTRL1   = 7'h00;
    localparam logic [6:0] ADDR_RXDATA  = 7'h08;
    localparam logic [6:0] ADDR_TXDATA  = 7'h0C;
    localparam logic [6:0] ADDR_STAT    = 7'h20;
    localparam logic [6:0] ADDR_SSEL    = 7'h24;
    localparam logic [7:0] CTRL1_INIT   = 8'h03;
    localparam int         STAT_RXEMPTY = 2;
    localparam logic [7:0] SS_MASK0     = 8'h01;
    localparam logic [7:0] SS_MASK1     = 8'h02;
    localparam logic [7:0] POLL_MAX     = 8'd255;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_SEL, S_LOAD, S_TX, S_POLL, S_RX, S_RSP, S_DESEL
    } state_t;

    state_t     state;
    logic       gnt;
    logic       last_gnt;
    logic       err;
    logic       last_q;
    logic [7:0] poll_cnt;
    logic       pick;
    logic [7:0] gnt_byte;

    // Contended grant goes to whoever was not served last.
    always_comb begin
        pick = req_valid[1];
        if (req_valid == 2'b11)
            pick = ~last_gnt;
    end

    assign gnt_byte = gnt ? req_data[15:8] : req_data[7:0];
    assign busy     = (state != S_IDLE);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state         <= S_INIT;
            gnt           <= 1'b0;
            last_gnt      <= 1'b1;
            err           <= 1'b0;
            last_q        <= 1'b0;
            poll_cnt      <= '0;
            bus.m_paddr   <= '0;
            bus.m_psel    <= 1'b0;
            bus.m_penable <= 1'b0;
            bus.m_pwrite  <= 1'b0;
            bus.m_pwdata  <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            if (bus.m_psel && !bus.m_penable) begin
                bus.m_penable <= 1'b1;
            end else if (bus.m_psel && bus.m_pready) begin
                // Transfer done; the next access, if any, is launched on this edge.
                bus.m_psel    <= 1'b0;
                bus.m_penable <= 1'b0;
                unique case (state)
                    S_INIT: begin
                        if (bus.m_pslverr)
                            bus.m_psel <= 1'b1;
                        else
                            state <= S_IDLE;
                    end
                    S_DESEL: begin
                        err      <= 1'b0;
                        last_gnt <= gnt;
                        state    <= S_IDLE;
                    end
                    default: begin
                        if (bus.m_pslverr) begin
                            err       <= 1'b1;
                            rsp_valid <= gnt ? 2'b10 : 2'b01;
                            rsp_err   <= 1'b1;
                            state     <= S_RSP;
                        end else begin
                            case (state)
                                S_SEL: state <= S_LOAD;
                                S_TX: begin
                                    poll_cnt     <= '0;
                                    bus.m_psel   <= 1'b1;
                                    bus.m_pwrite <= 1'b0;
                                    bus.m_paddr  <= ADDR_STAT;
                                    state        <= S_POLL;
                                end
                                S_POLL: begin
                                    if (!bus.m_prdata[STAT_RXEMPTY]) begin
                                        bus.m_psel  <= 1'b1;
                                        bus.m_paddr <= ADDR_RXDATA;
                                        state       <= S_RX;
                                    end else if (poll_cnt == POLL_MAX - 8'd1) begin
                                        err       <= 1'b1;
                                        rsp_valid <= gnt ? 2'b10 : 2'b01;
                                        rsp_err   <= 1'b1;
                                        state     <= S_RSP;
                                    end else begin
                                        poll_cnt   <= poll_cnt + 8'd1;
                                        bus.m_psel <= 1'b1;
                                    end
                                end
                                S_RX: begin
                                    rsp_data  <= bus.m_prdata;
                                    rsp_valid <= gnt ? 2'b10 : 2'b01;
                                    rsp_err   <= err;
                                    state     <= S_RSP;
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end else if (!bus.m_psel) begin
                unique case (state)
                    S_INIT: begin
                        bus.m_psel   <= 1'b1;
                        bus.m_pwrite <= 1'b1;
                        bus.m_paddr  <= ADDR_CTRL1;
                        bus.m_pwdata <= CTRL1_INIT;
                    end
                    S_IDLE: begin
                        if (|req_valid) begin
                            gnt          <= pick;
                            bus.m_psel   <= 1'b1;
                            bus.m_pwrite <= 1'b1;
                            bus.m_paddr  <= ADDR_SSEL;
                            bus.m_pwdata <= pick ? SS_MASK1 : SS_MASK0;
                            state        <= S_SEL;
                        end
                    end
                    S_LOAD: begin
                        // req_ready is registered, so capture happens in the strobe cycle.
                        if (req_ready[gnt]) begin
                            last_q       <= req_last[gnt];
                            bus.m_psel   <= 1'b1;
                            bus.m_pwrite <= 1'b1;
                            bus.m_paddr  <= ADDR_TXDATA;
                            bus.m_pwdata <= gnt_byte;
                            state        <= S_TX;
                        end else if (req_valid[gnt]) begin
                            req_ready[gnt] <= 1'b1;
                        end
                    end
                    S_RSP: begin
                        if (err || last_q) begin
                            bus.m_psel   <= 1'b1;
                            bus.m_pwrite <= 1'b1;
                            bus.m_paddr  <= ADDR_SSEL;
                            bus.m_pwdata <= 8'h00;
                            state        <= S_DESEL;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_corespi_txn_sequencer.sv
// Scoreboard bench for corespi_txn_sequencer with a scripted CoreSPI APB slave.
// Expected APB transfers and responses are queued by stimulus and popped by a monitor.
module tb_corespi_txn_sequencer;
    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err, busy;

    always #5 PCLK = ~PCLK;

    corespi_txn_sequencer_if bus ();

    corespi_txn_sequencer dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .bus(bus),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    // CoreSPI slave model
    logic [6:0] ws_addr = 7'h7f;
    logic [6:0] err_addr = 7'h7f;
    int         ws_n = 0;
    int         ws_cnt = 0;
    int         stat_empty_n = 0;
    int         stat_since = 0;
    int         rx_wr = 0;
    int         rx_idx = 0;
    logic [7:0] rx_mem [64];

    assign bus.m_pready  = bus.m_psel && bus.m_penable && (ws_cnt == 0);
    assign bus.m_pslverr = bus.m_pready && (bus.m_paddr == err_addr);
    assign bus.m_prdata  = (bus.m_paddr == 7'h20) ?
                           ((stat_since < stat_empty_n) ? 8'h04 : 8'hFB) :
                           (bus.m_paddr == 7'h08) ? rx_mem[rx_idx[5:0]] : 8'h00;

    always @(posedge PCLK) begin
        if (bus.m_psel && !bus.m_penable)
            ws_cnt <= (bus.m_paddr == ws_addr) ? ws_n : 0;
        else if (bus.m_psel && ws_cnt != 0)
            ws_cnt <= ws_cnt - 1;
        if (bus.m_pready) begin
            if (bus.m_pwrite && bus.m_paddr == 7'h0C) stat_since <= 0;
            if (!bus.m_pwrite && bus.m_paddr == 7'h20) stat_since <= stat_since + 1;
            if (!bus.m_pwrite && bus.m_paddr == 7'h08) rx_idx <= rx_idx + 1;
        end
    end

    // Requester drivers: {last, byte} entries, popped on req_ready
    logic [8:0] rq0 [$];
    logic [8:0] rq1 [$];

    always @(posedge PCLK) begin
        if (req_ready[0] && rq0.size() != 0) void'(rq0.pop_front());
        if (req_ready[1] && rq1.size() != 0) void'(rq1.pop_front());
        req_valid[0] <= (rq0.size() != 0);
        req_valid[1] <= (rq1.size() != 0);
        if (rq0.size() != 0) begin
            req_data[7:0] <= rq0[0][7:0];
            req_last[0]   <= rq0[0][8];
        end
        if (rq1.size() != 0) begin
            req_data[15:8] <= rq1[0][7:0];
            req_last[1]    <= rq1[0][8];
        end
    end

    // Scoreboard
    typedef struct { bit we; logic [6:0] a; logic [7:0] d; } apb_t;
    typedef struct { int r; logic [7:0] d; bit err; int lat; } rsp_t;
    apb_t apb_q [$];
    rsp_t rsp_q [$];
    apb_t ae;
    rsp_t re;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_cyc = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ew(input logic [6:0] a, input logic [7:0] d);
        apb_t e;
        e.we = 1'b1; e.a = a; e.d = d;
        apb_q.push_back(e);
    endtask

    task automatic er(input logic [6:0] a);
        apb_t e;
        e.we = 1'b0; e.a = a; e.d = 8'h00;
        apb_q.push_back(e);
    endtask

    task automatic ersp(input int r, input logic [7:0] d, input bit err, input int lat);
        rsp_t e;
        e.r = r; e.d = d; e.err = err; e.lat = lat;
        rsp_q.push_back(e);
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_mem[rx_wr[5:0]] = d;
        rx_wr++;
    endtask

    always @(negedge PCLK) begin
        cyc++;
        if (PRESETN) begin
            if (req_ready != 2'b00) begin
                rdy_cyc = cyc;
                check($onehot(req_ready) && ((req_ready & req_valid) == req_ready),
                      "req_ready_valid", 32'(req_ready), 32'(req_valid));
            end
            if (bus.m_psel && bus.m_penable && bus.m_pready) begin
                if (apb_q.size() == 0) begin
                    check(1'b0, "apb_unexpected", 32'(bus.m_paddr), 32'h0);
                end else begin
                    ae = apb_q.pop_front();
                    check(bus.m_pwrite == ae.we && bus.m_paddr == ae.a &&
                          (!ae.we || bus.m_pwdata == ae.d), "apb_xfer",
                          32'({bus.m_pwrite, bus.m_paddr, bus.m_pwdata}),
                          32'({ae.we, ae.a, ae.d}));
                end
            end
            if (rsp_valid != 2'b00) begin
                check($onehot(rsp_valid) && ((rsp_valid & req_ready) == 2'b00),
                      "rsp_onehot", 32'(rsp_valid), 32'(req_ready));
                if (rsp_q.size() == 0) begin
                    check(1'b0, "rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    re = rsp_q.pop_front();
                    check(rsp_valid == ((re.r == 1) ? 2'b10 : 2'b01), "rsp_owner",
                          32'(rsp_valid), 32'(re.r));
                    check(rsp_err == re.err, "rsp_err", 32'(rsp_err), 32'(re.err));
                    if (!re.err)
                        check(rsp_data == re.d, "rsp_data", 32'(rsp_data), 32'(re.d));
                    if (re.lat >= 0)
                        check(cyc - rdy_cyc == re.lat, "rsp_latency",
                              32'(cyc - rdy_cyc), 32'(re.lat));
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((apb_q.size() != 0 || rsp_q.size() != 0 || busy ||
                rq0.size() != 0 || rq1.size() != 0) && n < 5000) begin
            @(negedge PCLK);
            n++;
        end
        check(n < 5000, name, 32'(n), 32'd5000);
        if (n >= 5000) begin
            apb_q.delete();
            rsp_q.delete();
        end
        repeat (2) @(negedge PCLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge PCLK);
        check(!bus.m_psel && !bus.m_penable && !bus.m_pwrite &&
              bus.m_paddr == 7'h00 && bus.m_pwdata == 8'h00, "reset_apb",
              32'({bus.m_psel, bus.m_penable, bus.m_pwrite, bus.m_paddr, bus.m_pwdata}), 32'h0);
        check(req_ready == 2'b00 && rsp_valid == 2'b00 && rsp_data == 8'h00 && !rsp_err,
              "reset_req", 32'({req_ready, rsp_valid, rsp_data, rsp_err}), 32'h0);
        check(busy == 1'b1, "reset_busy", 32'(busy), 32'h1);
        ew(7'h00, 8'h03);
        PRESETN = 1'b1;
        @(negedge PCLK);
        check(busy == 1'b1, "busy_cycle1", 32'(busy), 32'h1);
        @(negedge PCLK);
        check(busy == 1'b1, "busy_cycle2", 32'(busy), 32'h1);
        @(negedge PCLK);
        check(busy == 1'b0, "busy_cycle3", 32'(busy), 32'h0);
        wait_idle("init_done");

        // burst A5, 3C from requester 0
        rx_push(8'h5A); rx_push(8'hC3);
        ew(7'h24, 8'h01); ew(7'h0C, 8'hA5); er(7'h20); er(7'h08);
        ew(7'h0C, 8'h3C); er(7'h20); er(7'h08); ew(7'h24, 8'h00);
        ersp(0, 8'h5A, 1'b0, 7); ersp(0, 8'hC3, 1'b0, 7);
        rq0.push_back({1'b0, 8'hA5}); rq0.push_back({1'b1, 8'h3C});
        wait_idle("burst_two_bytes");

        // reset in the middle of polling
        stat_empty_n = 1000;
        ew(7'h24, 8'h02); ew(7'h0C, 8'h77);
        for (int i = 0; i < 50; i++) er(7'h20);
        rq1.push_back({1'b1, 8'h77});
        repeat (20) @(negedge PCLK);
        PRESETN = 1'b0;
        #1;
        check(!bus.m_psel && !bus.m_penable && busy, "async_abort",
              32'({bus.m_psel, bus.m_penable, busy}), 32'h1);
        apb_q.delete(); rsp_q.delete(); rq0.delete(); rq1.delete();
        stat_empty_n = 0;
        repeat (2) @(negedge PCLK);
        ew(7'h00, 8'h03);
        PRESETN = 1'b1;
        wait_idle("reinit");

        // both valid: 0 first, then 1 while 0 still asks, then 0
        rx_push(8'h81); rx_push(8'h82); rx_push(8'h83);
        ew(7'h24, 8'h01); ew(7'h0C, 8'h11); er(7'h20); er(7'h08); ew(7'h24, 8'h00);
        ew(7'h24, 8'h02); ew(7'h0C, 8'h22); er(7'h20); er(7'h08); ew(7'h24, 8'h00);
        ew(7'h24, 8'h01); ew(7'h0C, 8'h33); er(7'h20); er(7'h08); ew(7'h24, 8'h00);
        ersp(0, 8'h81, 1'b0, 7); ersp(1, 8'h82, 1'b0, 7); ersp(0, 8'h83, 1'b0, 7);
        rq0.push_back({1'b1, 8'h11}); rq0.push_back({1'b1, 8'h33});
        rq1.push_back({1'b1, 8'h22});
        wait_idle("round_robin");

        // STATUS never drains within 255 reads
        stat_empty_n = 255;
        ew(7'h24, 8'h02); ew(7'h0C, 8'h44);
        for (int i = 0; i < 255; i++) er(7'h20);
        ew(7'h24, 8'h00);
        ersp(1, 8'h00, 1'b1, -1);
        rq1.push_back({1'b1, 8'h44});
        wait_idle("poll_timeout");
        stat_empty_n = 0;
        rx_push(8'h99);
        ew(7'h24, 8'h01); ew(7'h0C, 8'h55); er(7'h20); er(7'h08); ew(7'h24, 8'h00);
        ersp(0, 8'h99, 1'b0, 7);
        rq0.push_back({1'b1, 8'h55});
        wait_idle("after_timeout");

        // slave error on TXDATA write
        err_addr = 7'h0C;
        ew(7'h24, 8'h02); ew(7'h0C, 8'h66); ew(7'h24, 8'h00);
        ersp(1, 8'h00, 1'b1, 3);
        rq1.push_back({1'b1, 8'h66});
        wait_idle("pslverr_tx");
        err_addr = 7'h7f;

        // three wait states on the TXDATA access
        ws_addr = 7'h0C;
        ws_n = 3;
        rx_push(8'h34);
        ew(7'h24, 8'h01); ew(7'h0C, 8'h12); er(7'h20); er(7'h08); ew(7'h24, 8'h00);
        ersp(0, 8'h34, 1'b0, 10);
        rq0.push_back({1'b1, 8'h12});
        wait_idle("wait_states");
        ws_addr = 7'h7f;
        ws_n = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
